// File: rtl/pmips_pkg.sv
// Shared pMIPS definitions: register-file geometry and the address type.
package pmips_pkg;

  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : pmips_pkg

// File: rtl/regs_rdmux.sv
// Zero-gated asynchronous read multiplexer over registers 1..31; address 0 reads as zero.
module regs_rdmux
  import pmips_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  reg_addr_t                     addr_i,
  input  logic [REG_COUNT-1:1][N-1:0]   regs_i,
  output logic [N-1:0]                  data_o
);

  always_comb begin
    data_o = '0;
    if (addr_i != '0) begin
      data_o = regs_i[addr_i];
    end
  end

endmodule : regs_rdmux

// File: rtl/regs.sv
// pMIPS register file: 32 x n bits, %0 hard-wired to zero, two async read ports,
// one sync write port addressed by Raddr2.
module regs
  import pmips_pkg::*;
#(
  parameter int unsigned n = 8
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         w,
  input  logic [n-1:0] Wdata,
  input  reg_addr_t    Raddr1,
  input  reg_addr_t    Raddr2,
  output logic [n-1:0] Rdata1,
  output logic [n-1:0] Rdata2
);

  // No storage exists for %0, so writes addressed to it simply fall away.
  logic [REG_COUNT-1:1][n-1:0] regs_q;
  logic [REG_COUNT-1:1][n-1:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (w && (Raddr2 != '0)) begin
      regs_d[Raddr2] = Wdata;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regs_rdmux #(.N(n)) u_rdmux1 (
    .addr_i (Raddr1),
    .regs_i (regs_q),
    .data_o (Rdata1)
  );

  regs_rdmux #(.N(n)) u_rdmux2 (
    .addr_i (Raddr2),
    .regs_i (regs_q),
    .data_o (Rdata2)
  );

endmodule : regs

// File: tb/tb_regs.sv
// Directed self-checking bench for the pMIPS register file (n = 8).
`timescale 1ns/1ps
module tb_regs;
  import pmips_pkg::*;

  logic       clk;
  logic       nReset;
  logic       w;
  logic [7:0] Wdata;
  reg_addr_t  Raddr1;
  reg_addr_t  Raddr2;
  logic [7:0] Rdata1;
  logic [7:0] Rdata2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  regs #(.n(8)) dut (
    .clk    (clk),
    .nReset (nReset),
    .w      (w),
    .Wdata  (Wdata),
    .Raddr1 (Raddr1),
    .Raddr2 (Raddr2),
    .Rdata1 (Rdata1),
    .Rdata2 (Rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge, leaving inputs and samples clear of it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    w = 1'b1; Raddr2 = a; Wdata = d;
    tick();
    w = 1'b0;
  endtask

  logic [7:0] exp_v;

  initial begin
    nReset = 1'b0; w = 1'b0; Wdata = '0; Raddr1 = '0; Raddr2 = '0;
    #12;
    nReset = 1'b1;
    tick();

    // 1: reset clears asynchronously, mid-cycle, and beats a coincident write
    wr(5'd3, 8'h55);
    Raddr1 = 5'd3; Raddr2 = 5'd3;
    #1;
    check("pre_reset_r1", Rdata1, 8'h55);
    #2;
    nReset = 1'b0;
    #0.5;
    check("async_reset_r1", Rdata1, 8'h00);
    check("async_reset_r2", Rdata2, 8'h00);
    for (int a = 0; a < 32; a++) begin
      Raddr1 = 5'(a); Raddr2 = 5'(31 - a);
      #0.1;
      check($sformatf("reset_r1_a%0d", a), Rdata1, 8'h00);
      check($sformatf("reset_r2_a%0d", 31 - a), Rdata2, 8'h00);
    end
    w = 1'b1; Raddr2 = 5'd4; Wdata = 8'hA5;
    tick();
    check("reset_prio_write", Rdata2, 8'h00);
    w = 1'b0;
    nReset = 1'b1;
    tick();
    tick();
    Raddr1 = 5'd3;
    #1;
    check("post_reset_r1", Rdata1, 8'h00);
    check("post_reset_r2", Rdata2, 8'h00);

    // 2: write/read with one-edge latency
    w = 1'b1; Raddr2 = 5'd2; Wdata = 8'd12;
    tick();
    check("wr2_r2", Rdata2, 8'd12);
    Raddr2 = 5'd1; Wdata = 8'd11;
    tick();
    w = 1'b0;
    Raddr1 = 5'd1; Raddr2 = 5'd2;
    #1;
    check("rd1_r1", Rdata1, 8'd11);
    check("rd2_r2", Rdata2, 8'd12);

    // 3: write disabled holds contents
    w = 1'b0; Raddr2 = 5'd2; Wdata = 8'hFF;
    tick(); tick(); tick();
    check("wdis_r2", Rdata2, 8'd12);

    // 4: register 0 ignores writes
    wr(5'd0, 8'hFF);
    Raddr1 = 5'd0;
    #1;
    check("zero_r2", Rdata2, 8'h00);
    check("zero_r1", Rdata1, 8'h00);

    // 5: read-during-write shows old value before the edge, new after
    wr(5'd5, 8'd3);
    Raddr1 = 5'd5; Raddr2 = 5'd5; w = 1'b1; Wdata = 8'd9;
    #1;
    check("rdw_old_r1", Rdata1, 8'd3);
    check("rdw_old_r2", Rdata2, 8'd3);
    tick();
    w = 1'b0;
    check("rdw_new_r1", Rdata1, 8'd9);
    check("rdw_new_r2", Rdata2, 8'd9);

    // 6: sweep all registers, read each address on both ports
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 8'(i * 7 + 1));
    end
    Wdata = 8'hEE;
    for (int a = 0; a < 32; a++) begin
      Raddr1 = 5'(a); Raddr2 = 5'(a);
      #1;
      exp_v = (a == 0) ? 8'h00 : 8'(a * 7 + 1);
      check($sformatf("sweep_r1_a%0d", a), Rdata1, exp_v);
      check($sformatf("sweep_r2_a%0d", a), Rdata2, exp_v);
    end
    Raddr1 = 5'd30; Raddr2 = 5'd17;
    #1;
    check("sweep_diff_r1", Rdata1, 8'd211);
    check("sweep_diff_r2", Rdata2, 8'd120);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_regs
